// File: rtl/snax_mx_tensor_core_ctrl_pkg.sv
// Shared types and CSR layout constants for the MX tensor core controller.
// Imported by snax_mx_tensor_core_ctrl and snax_mx_sat_counter.
package snax_mx_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2
   } ctrl_state_e;

   localparam int unsigned RW_K_IDX    = 0;
   localparam int unsigned RW_T_IDX    = 1;
   localparam int unsigned RW_MODE_IDX = 2;
   localparam int unsigned RW_AUX_IDX  = 3;

   localparam int unsigned RO_STATUS_IDX = 0;
   localparam int unsigned RO_CYCLES_IDX = 1;

   localparam int unsigned BUSY_BIT  = 0;
   localparam int unsigned ERR_BIT   = 1;
   localparam int unsigned TILES_LSB = 16;

   localparam int unsigned MODE_W = 3;

endpackage

// File: rtl/snax_mx_tensor_core_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module snax_mx_sat_counter
   import snax_mx_ctrl_pkg::*;
#(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = &r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (en_i && !w_at_max) begin
         r_cnt <= r_cnt + Width'(1);
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/snax_mx_tensor_core_ctrl.sv
// MX tensor core controller: latches the RW CSR set, launches the core, counts output tiles.
// Define SNAX_MX_CTRL_PERF_EN to instantiate the run-cycle counter reported in RO word1.
module snax_mx_tensor_core_ctrl
   import snax_mx_ctrl_pkg::*;
#(
   parameter int unsigned NumRwCsr = 4,
   parameter int unsigned NumRoCsr = 2,
   parameter int unsigned CntWidth = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumRwCsr-1:0][31:0] csr_reg_rw_set_i,
   input  logic                      csr_reg_set_valid_i,
   output logic                      csr_reg_set_ready_o,
   output logic [NumRoCsr-1:0][31:0] csr_reg_ro_set_o,
   output logic                      core_start_valid_o,
   input  logic                      core_start_ready_i,
   output logic [CntWidth-1:0]       core_cfg_k_o,
   output logic [MODE_W-1:0]         core_cfg_mode_o,
   output logic [31:0]               core_cfg_aux_o,
   input  logic                      core_tile_done_i,
   output logic                      core_busy_o
);

   ctrl_state_e         r_state;
   ctrl_state_e         w_state_nxt;
   logic                r_init;
   logic                r_err;
   logic [CntWidth-1:0] r_k;
   logic [CntWidth-1:0] r_t;
   logic [MODE_W-1:0]   r_mode;
   logic [31:0]         r_aux;

   logic [CntWidth-1:0] w_k_in;
   logic [CntWidth-1:0] w_t_in;
   logic                w_accept;
   logic                w_cfg_zero;
   logic                w_tile_en;
   logic                w_last_tile;
   logic [CntWidth-1:0] w_tiles;
   logic [15:0]         w_tiles16;
   logic [31:0]         w_cycles;
   logic                w_unused_bits;

   assign w_k_in     = csr_reg_rw_set_i[RW_K_IDX][CntWidth-1:0];
   assign w_t_in     = csr_reg_rw_set_i[RW_T_IDX][CntWidth-1:0];
   assign w_cfg_zero = (w_k_in == '0) || (w_t_in == '0);

   // r_init keeps ready low while in reset and for the edge that releases it.
   assign csr_reg_set_ready_o = r_init && (r_state == IDLE);
   assign w_accept            = csr_reg_set_valid_i && csr_reg_set_ready_o;
   assign core_start_valid_o  = (r_state == LAUNCH);
   assign core_busy_o         = (r_state != IDLE);

   assign w_tile_en   = (r_state == RUN) && core_tile_done_i;
   assign w_last_tile = w_tile_en &&
                        (({1'b0, w_tiles} + (CntWidth + 1)'(1)) == {1'b0, r_t});

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept && !w_cfg_zero) w_state_nxt = LAUNCH;
         LAUNCH:  if (core_start_ready_i) w_state_nxt = RUN;
         RUN:     if (w_last_tile) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_init  <= 1'b0;
         r_err   <= 1'b0;
         r_k     <= '0;
         r_t     <= '0;
         r_mode  <= '0;
         r_aux   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_init  <= 1'b1;
         if (w_accept) begin
            r_k    <= w_k_in;
            r_t    <= w_t_in;
            r_mode <= csr_reg_rw_set_i[RW_MODE_IDX][MODE_W-1:0];
            r_aux  <= csr_reg_rw_set_i[RW_AUX_IDX];
            r_err  <= w_cfg_zero;
         end
      end
   end

   snax_mx_sat_counter #(
      .Width (CntWidth)
   ) u_tile_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (w_accept),
      .en_i  (w_tile_en),
      .cnt_o (w_tiles)
   );

`ifdef SNAX_MX_CTRL_PERF_EN
   snax_mx_sat_counter #(
      .Width (32)
   ) u_cycle_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (w_accept && !w_cfg_zero),
      .en_i  (r_state != IDLE),
      .cnt_o (w_cycles)
   );
`else
   assign w_cycles = '0;
`endif

   assign w_tiles16 = 16'(w_tiles);

   always_comb begin
      csr_reg_ro_set_o                                 = '0;
      csr_reg_ro_set_o[RO_STATUS_IDX][TILES_LSB +: 16] = w_tiles16;
      csr_reg_ro_set_o[RO_STATUS_IDX][ERR_BIT]         = r_err;
      csr_reg_ro_set_o[RO_STATUS_IDX][BUSY_BIT]        = core_busy_o;
      csr_reg_ro_set_o[RO_CYCLES_IDX]                  = w_cycles;
   end

   assign core_cfg_k_o    = r_k;
   assign core_cfg_mode_o = r_mode;
   assign core_cfg_aux_o  = r_aux;

   // Upper bits of the RW words carry no meaning for this block.
   assign w_unused_bits = ^{csr_reg_rw_set_i[RW_K_IDX][31:CntWidth],
                            csr_reg_rw_set_i[RW_T_IDX][31:CntWidth],
                            csr_reg_rw_set_i[RW_MODE_IDX][31:MODE_W]};

endmodule

// File: tb/tb_snax_mx_tensor_core_ctrl.sv
// Scoreboard bench for snax_mx_tensor_core_ctrl: drivers push expected accept/launch/done
// records, an independent monitor pops and compares them as the DUT presents each event.
module tb_snax_mx_tensor_core_ctrl;

`ifdef SNAX_MX_CTRL_PERF_EN
   localparam bit Perf = 1'b1;
`else
   localparam bit Perf = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0][31:0] rw_set;
   logic             set_valid;
   logic             set_ready;
   logic [1:0][31:0] ro_set;
   logic             start_valid;
   logic             start_ready;
   logic [15:0]      cfg_k;
   logic [2:0]       cfg_mode;
   logic [31:0]      cfg_aux;
   logic             tile_done;
   logic             busy;

   always #5 clk = ~clk;

   snax_mx_tensor_core_ctrl #(
      .NumRwCsr (4),
      .NumRoCsr (2),
      .CntWidth (16)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .csr_reg_rw_set_i    (rw_set),
      .csr_reg_set_valid_i (set_valid),
      .csr_reg_set_ready_o (set_ready),
      .csr_reg_ro_set_o    (ro_set),
      .core_start_valid_o  (start_valid),
      .core_start_ready_i  (start_ready),
      .core_cfg_k_o        (cfg_k),
      .core_cfg_mode_o     (cfg_mode),
      .core_cfg_aux_o      (cfg_aux),
      .core_tile_done_i    (tile_done),
      .core_busy_o         (busy)
   );

   typedef struct packed {
      logic [15:0] k;
      logic [15:0] t;
      logic [2:0]  mode;
      logic [31:0] aux;
   } cfg_t;

   typedef struct {
      logic [31:0] ro0;
      cfg_t        c;
   } acc_t;

   typedef struct {
      cfg_t c;
      int   len;
   } launch_t;

   typedef struct {
      logic [31:0] ro0;
      logic [31:0] ro1;
   } done_t;

   acc_t    q_acc[$];
   launch_t q_launch[$];
   done_t   q_done[$];
   int      g_fixed[$];
   int      checks = 0;
   int      errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic cfg_t mk_cfg(input int k, input int t, input int mode, input int aux);
      cfg_t c;
      c.k    = 16'(k);
      c.t    = 16'(t);
      c.mode = 3'(mode);
      c.aux  = 32'(aux);
      return c;
   endfunction

   // ---------------- monitor ----------------
   bit      m_prev_busy = 1'b0;
   bit      m_pend = 1'b0;
   int      m_sv_cnt = 0;
   acc_t    m_a;
   launch_t m_l;
   done_t   m_d;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_prev_busy = 1'b0;
            m_pend      = 1'b0;
            m_sv_cnt    = 0;
         end else begin
            if (m_pend) begin
               m_pend = 1'b0;
               if (q_acc.size() == 0) chk("acc_unexpected", 1, 0);
               else begin
                  m_a = q_acc.pop_front();
                  chk("acc_ro0", ro_set[0], m_a.ro0);
                  chk("acc_cfg_k", cfg_k, m_a.c.k);
                  chk("acc_cfg_mode", cfg_mode, m_a.c.mode);
                  chk("acc_cfg_aux", cfg_aux, m_a.c.aux);
               end
            end
            if (set_valid && set_ready) m_pend = 1'b1;
            if (start_valid) begin
               m_sv_cnt++;
               if (start_ready) begin
                  if (q_launch.size() == 0) chk("launch_unexpected", 1, 0);
                  else begin
                     m_l = q_launch.pop_front();
                     chk("launch_k", cfg_k, m_l.c.k);
                     chk("launch_mode", cfg_mode, m_l.c.mode);
                     chk("launch_aux", cfg_aux, m_l.c.aux);
                     chk("launch_len", m_sv_cnt, m_l.len);
                  end
                  m_sv_cnt = 0;
               end
            end
            if (m_prev_busy && !busy) begin
               if (q_done.size() == 0) chk("done_unexpected", 1, 0);
               else begin
                  m_d = q_done.pop_front();
                  chk("done_ro0", ro_set[0], m_d.ro0);
                  chk("done_ro1", ro_set[1], m_d.ro1);
                  chk("done_ready", set_ready, 1);
               end
            end
            m_prev_busy = busy;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic drive_set(input cfg_t c);
      rw_set[0] = {16'($urandom), c.k};
      rw_set[1] = {16'($urandom), c.t};
      rw_set[2] = {29'($urandom), c.mode};
      rw_set[3] = c.aux;
   endtask

   task automatic wait_accept();
      bit acc = 1'b0;
      int n   = 0;
      while (!acc && n < 60) begin
         @(negedge clk);
         acc = set_ready;
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept_in_time", acc, 1);
      set_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      set_valid   = 1'b0;
      start_ready = 1'b0;
      tile_done   = 1'b0;
      #1;
      chk("rst_ready", set_ready, 0);
      chk("rst_start_valid", start_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ro0", ro_set[0], 0);
      chk("rst_ro1", ro_set[1], 0);
      chk("rst_cfg", {cfg_k, cfg_mode, cfg_aux}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_low_at_release", set_ready, 0);
      @(posedge clk);
      #1;
      chk("ready_after_reset", set_ready, 1);
   endtask

   task automatic relatch_chk(input cfg_t c);
      chk("relatch_ready", set_ready, 0);
      chk("relatch_cfg", {cfg_k, cfg_mode, cfg_aux}, {c.k, c.mode, c.aux});
   endtask

   // Runs one full job; d = cycles start_ready stays low. With relatch, nxt is
   // presented during RUN and must be held off until completion.
   task automatic do_run(input cfg_t c, input int d, input bit relatch, input cfg_t nxt);
      int      gaps[$];
      int      r_cyc = 0;
      acc_t    a;
      launch_t l;
      done_t   dn;
      for (int i = 0; i < int'(c.t); i++) begin
         int g;
         g = (g_fixed.size() > 0) ? g_fixed.pop_front() : int'($urandom_range(0, 3));
         gaps.push_back(g);
         r_cyc += g + 1;
      end
      a.ro0 = 32'h1;
      a.c   = c;
      q_acc.push_back(a);
      l.c   = c;
      l.len = d + 1;
      q_launch.push_back(l);
      dn.ro0 = {c.t, 16'h0};
      dn.ro1 = Perf ? 32'(d + 1 + r_cyc) : 32'h0;
      q_done.push_back(dn);

      drive_set(c);
      set_valid = 1'b1;
      wait_accept();
      for (int i = 0; i < d; i++) begin
         start_ready = 1'b0;
         tile_done   = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      start_ready = 1'b1;
      tile_done   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      start_ready = 1'b0;
      tile_done   = 1'b0;
      if (relatch) begin
         drive_set(nxt);
         set_valid = 1'b1;
      end
      foreach (gaps[i]) begin
         for (int j = 0; j < gaps[i]; j++) begin
            if (relatch) relatch_chk(c);
            @(posedge clk);
            #1;
         end
         if (relatch) relatch_chk(c);
         tile_done = 1'b1;
         @(posedge clk);
         #1;
         tile_done = 1'b0;
      end
      chk("ready_after_last_tile", set_ready, 1);
      chk("busy_after_last_tile", busy, 0);
   endtask

   task automatic do_err(input cfg_t c);
      acc_t a;
      a.ro0 = 32'h2;
      a.c   = c;
      q_acc.push_back(a);
      drive_set(c);
      set_valid = 1'b1;
      wait_accept();
      repeat (3) begin
         chk("err_no_launch", start_valid, 0);
         chk("err_ready", set_ready, 1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_abort(input cfg_t c);
      acc_t    a;
      launch_t l;
      a.ro0 = 32'h1;
      a.c   = c;
      q_acc.push_back(a);
      l.c   = c;
      l.len = 2;
      q_launch.push_back(l);
      drive_set(c);
      set_valid = 1'b1;
      wait_accept();
      start_ready = 1'b0;
      @(posedge clk);
      #1;
      start_ready = 1'b1;
      @(posedge clk);
      #1;
      start_ready = 1'b0;
      repeat (2) begin
         tile_done = 1'b1;
         @(posedge clk);
         #1;
         tile_done = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("abort_tiles_before", ro_set[0], 32'h0002_0001);
      do_reset();
   endtask

   cfg_t dummy;
   cfg_t c1;
   cfg_t c2;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rw_set      = '0;
      set_valid   = 1'b0;
      start_ready = 1'b0;
      tile_done   = 1'b0;
      dummy       = '0;
      do_reset();

      g_fixed = '{4, 3, 2};
      do_run(mk_cfg(4, 3, 2, 32'hA5A5_0001), 0, 1'b0, dummy);

      do_err(mk_cfg(5, 0, 1, 32'h1234_5678));
      do_err(mk_cfg(0, 2, 3, 32'h0BAD_F00D));
      do_run(mk_cfg(1, 1, 0, 32'h0000_0042), 0, 1'b0, dummy);

      do_run(mk_cfg(7, 2, 5, 32'hCAFE_0007), 10, 1'b0, dummy);

      c1 = mk_cfg(9, 4, 6, 32'h1111_2222);
      c2 = mk_cfg(3, 2, 1, 32'h3333_4444);
      do_run(c1, 2, 1'b1, c2);
      do_run(c2, 1, 1'b0, dummy);

      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            do_err(mk_cfg(int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 7)),
                          int'($urandom)));
         end
         do_run(mk_cfg(int'($urandom_range(1, 65535)), int'($urandom_range(1, 6)),
                       int'($urandom_range(0, 7)), int'($urandom)),
                int'($urandom_range(0, 4)), 1'b0, dummy);
      end

      do_abort(mk_cfg(8, 5, 4, 32'hDEAD_BEEF));
      do_run(mk_cfg(2, 2, 3, 32'h0000_00AA), 0, 1'b0, dummy);

      repeat (4) @(posedge clk);
      #1;
      chk("acc_queue_drained", q_acc.size(), 0);
      chk("launch_queue_drained", q_launch.size(), 0);
      chk("done_queue_drained", q_done.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
